seq_divider: RTL and testbench

- Multi-cycle unsigned integer divider, radix-2 restoring algorithm, one quotient bit per clock.
- Replaces the single-cycle combinational divide path in the ALU datapath so that path no longer limits clock period.
- Consumes operands through a valid/ready request interface and returns quotient and remainder through a valid/ready response interface.
- One operation in flight at a time.

---
 rtl/alu_pkg.sv | 14 +
 rtl/seq_divider_div_step.sv | 26 ++
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, default width and divide-by-zero quotient.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring divide iteration: shift {rem, quot} left and try to subtract the divisor.
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    assign shifted_rem = {rem, quot[WIDTH-1]};
    assign diff        = {1'b0, shifted_rem} - {2'b00, divisor};
    // A non-borrowing trial is always below the divisor, so bit WIDTH can only be set on a borrow.
    assign borrow      = |diff[WIDTH+1:WIDTH];

    assign rem_next  = borrow ? shifted_rem[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_next = {quot[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
module seq_divider
    import alu_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    div_state_t       state_next;
    logic             accept;
    logic             last_iter;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] divisor_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_step;
    logic [WIDTH-1:0] rem_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (divisor_q),
        .rem_next  (rem_step),
        .quot_next (quot_step)
    );

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            dbz_q     <= 1'b0;
        end else if (accept) begin
            divisor_q <= divisor;
            cnt       <= '0;
            if (divisor == '0) begin
                quot_q <= {WIDTH{1'b1}};
                rem_q  <= dividend;
                dbz_q  <= 1'b1;
            end else begin
                quot_q <= dividend;
                rem_q  <= '0;
                dbz_q  <= 1'b0;
            end
        end else if (state == BUSY) begin
            quot_q <= quot_step;
            rem_q  <= rem_step;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic/latency model checked every cycle, directed cases and random traffic.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    // Model: result of the last accepted operation and how many edges remain until it is shown.
    bit           m_done = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_z = 1'b0;

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) begin
        m_done <= 1'b0;
        m_left <= 0;
        m_q    <= '0;
        m_r    <= '0;
        m_z    <= 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_done) begin
                if (out_ready) m_done <= 1'b0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_done <= 1'b1;
            end else if (in_valid) begin
                if (divisor == '0) begin
                    m_q    <= '1;
                    m_r    <= dividend;
                    m_z    <= 1'b1;
                    m_done <= 1'b1;
                end else begin
                    m_q    <= dividend / divisor;
                    m_r    <= dividend % divisor;
                    m_z    <= 1'b0;
                    m_left <= W;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", W'(in_ready), W'(!m_done && m_left == 0));
        chk("out_valid", W'(out_valid), W'(m_done));
        if (m_left == 0) begin
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_by_zero", W'(div_by_zero), W'(m_z));
        end
    end

    // Called at posedge+1; returns result and number of edges after the accept edge until out_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                          output int lat);
        int n;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) chk("out_valid_timeout", W'(out_valid), W'(1));
        q = quotient;
        r = remainder;
        z = div_by_zero;
        for (int i = 0; i < hold; i++) begin
            dividend = $urandom;
            divisor  = $urandom;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_ack", W'(in_ready), W'(1));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = W'($urandom_range(0, 15));
            3:       v = W'(1);
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] q, r, a, b, eq, er;
        logic         z;
        int           lat;

        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", W'(in_ready), W'(1));
        chk("reset_quotient", quotient, W'(0));

        run_op(W'(100), W'(7), 0, q, r, z, lat);
        chk("q_100_7", q, W'(14));
        chk("r_100_7", r, W'(2));
        chk("z_100_7", W'(z), W'(0));
        chk("lat_100_7", W'(lat), W'(32));

        run_op(W'(5), W'(0), 0, q, r, z, lat);
        chk("q_5_0", q, 32'hFFFF_FFFF);
        chk("r_5_0", r, W'(5));
        chk("z_5_0", W'(z), W'(1));
        chk("lat_5_0", W'(lat), W'(0));

        run_op(32'hFFFF_FFFF, W'(1), 0, q, r, z, lat);
        chk("q_max_1", q, 32'hFFFF_FFFF);
        chk("r_max_1", r, W'(0));

        run_op(W'(3), W'(10), 0, q, r, z, lat);
        chk("q_3_10", q, W'(0));
        chk("r_3_10", r, W'(3));

        run_op(W'(1000), W'(10), 10, q, r, z, lat);
        chk("q_backpressure", q, W'(100));
        chk("r_backpressure", r, W'(0));

        dividend = W'(1000);
        divisor  = W'(3);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_in_ready", W'(in_ready), W'(1));
        chk("abort_quotient", quotient, W'(0));
        chk("abort_remainder", remainder, W'(0));
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(W'(81), W'(9), 0, q, r, z, lat);
        chk("q_81_9", q, W'(9));
        chk("r_81_9", r, W'(0));

        for (int k = 0; k < 1000; k++) begin
            a = pick();
            b = pick();
            run_op(a, b, $urandom_range(0, 2), q, r, z, lat);
            if (b == '0) begin
                eq = '1;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            chk("rand_q", q, eq);
            chk("rand_r", r, er);
            chk("rand_z", W'(z), W'(b == '0));
            chk("rand_lat", W'(lat), (b == '0) ? W'(0) : W'(32));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
